// File: rtl/vector_mem_responder.sv
// Memory-side responder: byte-addressed little-endian RAM serving a fetch port and a
// scalar/vector data port. Optional macro MEM_MISALIGN_CHECK_EN turns misaligned data accesses into ERROR.
module vector_mem_responder #(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int BYTE_SIZE        = 8,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int MEM_LATENCY      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          inst_fetch_enabled,
  input  logic [ADDR_WIDTH-1:0]         mem_inst_addr,
  output logic [LEN-1:0]                instruction,
  input  logic                          mem_vis_enabled,
  input  logic [1:0]                    memory_vis_signal,
  input  logic [2:0]                    data_type,
  input  logic [ADDR_WIDTH-1:0]         mem_data_addr,
  input  logic [ENTRY_INDEX_SIZE:0]     vector_length,
  input  logic [LEN-1:0]                mem_write_scalar_data,
  input  logic [LEN*VECTOR_SIZE-1:0]    mem_write_vector_data,
  output logic [LEN-1:0]                mem_read_scalar_data,
  output logic [LEN*VECTOR_SIZE-1:0]    mem_read_vector_data,
  output logic [1:0]                    mem_vis_status
);
  localparam int BPW   = LEN / BYTE_SIZE;
  localparam int OFF_W = $clog2(BPW);
  localparam int ROW_W = ADDR_WIDTH - OFF_W;
  localparam int DEPTH = 1 << ROW_W;
  localparam int LAT_W = $clog2(MEM_LATENCY + 1);
  localparam int CNT_W = ENTRY_INDEX_SIZE + 1;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;
  localparam logic [1:0] ST_ERROR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t                     state_reg, state_next;
  logic [LAT_W-1:0]           lat_reg, lat_next;
  logic [CNT_W-1:0]           elem_reg, elem_next;
  logic [ADDR_WIDTH-1:0]      addr_reg;
  logic [1:0]                 type_reg;
  logic                       write_reg;
  logic [CNT_W-1:0]           len_reg;
  logic [LEN-1:0]             wdata_reg;
  logic [LEN*VECTOR_SIZE-1:0] wvec_reg;
  logic                       fetch_valid_reg;
  logic [OFF_W-1:0]           fetch_off_reg;

  logic req_legal, accept, is_vec, misaligned, last_elem, do_access;
  logic [CNT_W-1:0] len_in;

  assign req_legal = mem_vis_enabled && !data_type[2] &&
                     (memory_vis_signal == 2'b01 || memory_vis_signal == 2'b10);
  assign accept    = (state_reg == S_IDLE) && req_legal;
  assign len_in    = (vector_length > CNT_W'(VECTOR_SIZE)) ? CNT_W'(VECTOR_SIZE) : vector_length;
  assign is_vec    = (type_reg == 2'b11);
  assign last_elem = (len_reg == '0) || (elem_reg == len_reg - 1'b1);

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    case (type_reg)
      2'b01:   misaligned = addr_reg[0];
      2'b10,
      2'b11:   misaligned = (addr_reg[OFF_W-1:0] != '0);
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  assign do_access = (state_reg == S_ACCESS) && !misaligned && (!is_vec || elem_reg < len_reg);

  always_comb begin
    state_next     = state_reg;
    lat_next       = lat_reg;
    elem_next      = elem_reg;
    mem_vis_status = ST_IDLE;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_WAIT;
          lat_next   = LAT_W'(MEM_LATENCY - 1);
          elem_next  = '0;
        end
      end
      S_WAIT: begin
        mem_vis_status = ST_BUSY;
        if (lat_reg == '0) state_next = S_ACCESS;
        else               lat_next   = lat_reg - 1'b1;
      end
      S_ACCESS: begin
        mem_vis_status = ST_BUSY;
        if (misaligned || !is_vec || last_elem) state_next = S_DONE;
        else                                    elem_next  = elem_reg + 1'b1;
      end
      default: begin
        mem_vis_status = misaligned ? ST_ERROR : ST_DONE;
        state_next     = S_IDLE;
      end
    endcase
  end

  // The data read port runs one element ahead: the last WAIT edge fetches element 0,
  // and each ACCESS edge fetches element i+1 while element i is consumed.
  logic [CNT_W-1:0]      rd_elem;
  logic [ADDR_WIDTH-1:0] wr_base, rd_base;
  logic [LEN-1:0]        wr_word;
  logic [OFF_W:0]        nbytes;

  assign rd_elem = (state_reg == S_ACCESS) ? elem_reg + 1'b1 : '0;
  assign wr_base = addr_reg + (ADDR_WIDTH'(elem_reg) << OFF_W);
  assign rd_base = addr_reg + (ADDR_WIDTH'(rd_elem) << OFF_W);
  assign wr_word = is_vec ? wvec_reg[LEN*elem_reg[ENTRY_INDEX_SIZE-1:0] +: LEN] : wdata_reg;

  always_comb begin
    case (type_reg)
      2'b00:   nbytes = (OFF_W+1)'(1);
      2'b01:   nbytes = (OFF_W+1)'(2);
      default: nbytes = (OFF_W+1)'(BPW);
    endcase
  end

  logic [LEN-1:0] data_bytes, fetch_bytes;

  // Bank gi holds bytes whose address low bits equal gi, so any BPW consecutive bytes
  // (aligned or not) touch each bank exactly once.
  for (genvar gi = 0; gi < BPW; gi++) begin : g_bank
    logic [BYTE_SIZE-1:0] ram [DEPTH];
    logic [BYTE_SIZE-1:0] data_q, fetch_q;
    logic [OFF_W-1:0]     d_ofs, f_ofs;
    logic [ROW_W-1:0]     wr_row, rd_row, f_row;
    logic                 we;

    assign d_ofs  = OFF_W'(gi) - addr_reg[OFF_W-1:0];
    assign f_ofs  = OFF_W'(gi) - mem_inst_addr[OFF_W-1:0];
    assign wr_row = ROW_W'((wr_base + ADDR_WIDTH'(d_ofs)) >> OFF_W);
    assign rd_row = ROW_W'((rd_base + ADDR_WIDTH'(d_ofs)) >> OFF_W);
    assign f_row  = ROW_W'((mem_inst_addr + ADDR_WIDTH'(f_ofs)) >> OFF_W);
    assign we     = rst && do_access && write_reg && ({1'b0, d_ofs} < nbytes);

    always_ff @(posedge clk) begin
      if (we) ram[wr_row] <= wr_word[BYTE_SIZE*d_ofs +: BYTE_SIZE];
      data_q <= ram[rd_row];
      if (inst_fetch_enabled) fetch_q <= ram[f_row];
    end

    assign data_bytes[BYTE_SIZE*gi +: BYTE_SIZE]  = data_q;
    assign fetch_bytes[BYTE_SIZE*gi +: BYTE_SIZE] = fetch_q;
  end

  logic [LEN-1:0]   data_word, fetch_word;
  logic [OFF_W-1:0] dsel, fsel;

  always_comb begin
    data_word  = '0;
    fetch_word = '0;
    dsel       = '0;
    fsel       = '0;
    for (int k = 0; k < BPW; k++) begin
      dsel = addr_reg[OFF_W-1:0] + OFF_W'(k);
      fsel = fetch_off_reg + OFF_W'(k);
      data_word[BYTE_SIZE*k +: BYTE_SIZE]  = data_bytes[BYTE_SIZE*dsel +: BYTE_SIZE];
      fetch_word[BYTE_SIZE*k +: BYTE_SIZE] = fetch_bytes[BYTE_SIZE*fsel +: BYTE_SIZE];
    end
  end

  assign instruction = fetch_valid_reg ? fetch_word : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg            <= S_IDLE;
      lat_reg              <= '0;
      elem_reg             <= '0;
      addr_reg             <= '0;
      type_reg             <= '0;
      write_reg            <= 1'b0;
      len_reg              <= '0;
      wdata_reg            <= '0;
      wvec_reg             <= '0;
      fetch_valid_reg      <= 1'b0;
      fetch_off_reg        <= '0;
      mem_read_scalar_data <= '0;
      mem_read_vector_data <= '0;
    end else begin
      state_reg <= state_next;
      lat_reg   <= lat_next;
      elem_reg  <= elem_next;
      if (inst_fetch_enabled) begin
        fetch_valid_reg <= 1'b1;
        fetch_off_reg   <= mem_inst_addr[OFF_W-1:0];
      end
      if (accept) begin
        addr_reg  <= mem_data_addr;
        type_reg  <= data_type[1:0];
        write_reg <= (memory_vis_signal == 2'b10);
        len_reg   <= len_in;
        wdata_reg <= mem_write_scalar_data;
        wvec_reg  <= mem_write_vector_data;
      end
      // Lanes beyond the vector length must read back as zero.
      if (state_reg == S_WAIT && lat_reg == '0 && is_vec && !write_reg && !misaligned)
        mem_read_vector_data <= '0;
      if (do_access && !write_reg) begin
        if (is_vec) begin
          mem_read_vector_data[LEN*elem_reg[ENTRY_INDEX_SIZE-1:0] +: LEN] <= data_word;
        end else begin
          case (type_reg)
            2'b00:   mem_read_scalar_data <= LEN'(data_word[BYTE_SIZE-1:0]);
            2'b01:   mem_read_scalar_data <= LEN'(data_word[2*BYTE_SIZE-1:0]);
            default: mem_read_scalar_data <= data_word;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_vector_mem_responder.sv
// Directed self-checking bench for vector_mem_responder (default parameters).
module tb_vector_mem_responder;
  localparam int AW  = 17;
  localparam int LEN = 32;
  localparam int VS  = 8;

  localparam logic [1:0] OP_RD = 2'b01, OP_WR = 2'b10;
  localparam logic [2:0] DT_B = 3'd0, DT_H = 3'd1, DT_W = 3'd2, DT_V = 3'd3;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10, ERR = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic              inst_fetch_enabled;
  logic [AW-1:0]     mem_inst_addr;
  logic [LEN-1:0]    instruction;
  logic              mem_vis_enabled;
  logic [1:0]        memory_vis_signal;
  logic [2:0]        data_type;
  logic [AW-1:0]     mem_data_addr;
  logic [3:0]        vector_length;
  logic [LEN-1:0]    mem_write_scalar_data;
  logic [LEN*VS-1:0] mem_write_vector_data;
  logic [LEN-1:0]    mem_read_scalar_data;
  logic [LEN*VS-1:0] mem_read_vector_data;
  logic [1:0]        mem_vis_status;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vector_mem_responder dut (
    .clk(clk), .rst(rst),
    .inst_fetch_enabled(inst_fetch_enabled), .mem_inst_addr(mem_inst_addr), .instruction(instruction),
    .mem_vis_enabled(mem_vis_enabled), .memory_vis_signal(memory_vis_signal), .data_type(data_type),
    .mem_data_addr(mem_data_addr), .vector_length(vector_length),
    .mem_write_scalar_data(mem_write_scalar_data), .mem_write_vector_data(mem_write_vector_data),
    .mem_read_scalar_data(mem_read_scalar_data), .mem_read_vector_data(mem_read_vector_data),
    .mem_vis_status(mem_vis_status)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one request for one edge, then counts edges until DONE/ERROR (bounded) and
  // waits out the DONE cycle. Called and returns at posedge+1.
  task automatic do_req(input logic [1:0] op, input logic [2:0] dt, input logic [AW-1:0] addr,
                        input logic [3:0] vlen, input logic [LEN-1:0] wd, input logic [LEN*VS-1:0] wv,
                        output int n, output logic [1:0] fin, output logic [1:0] first,
                        output int busy, output logic [1:0] post);
    mem_vis_enabled = 1'b1; memory_vis_signal = op; data_type = dt; mem_data_addr = addr;
    vector_length = vlen; mem_write_scalar_data = wd; mem_write_vector_data = wv;
    @(posedge clk); #1;
    mem_vis_enabled = 1'b0; memory_vis_signal = 2'b00;
    first = mem_vis_status; n = 0; busy = 0; fin = IDLE;
    while (n < 64) begin
      @(posedge clk); #1; n++;
      if (mem_vis_status == BUSY) busy++;
      else begin
        fin = mem_vis_status;
        break;
      end
    end
    @(posedge clk); #1;
    post = mem_vis_status;
  endtask

  task automatic test_reset();
    int n, busy; logic [1:0] fin, first, post;
    rst = 1'b0; inst_fetch_enabled = 1'b0; mem_inst_addr = '0; mem_vis_enabled = 1'b0;
    memory_vis_signal = 2'b00; data_type = 3'd0; mem_data_addr = '0; vector_length = '0;
    mem_write_scalar_data = '0; mem_write_vector_data = '0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    checks++; if (mem_vis_status !== IDLE) begin failures++; $display("FAIL reset_status got=%0h exp=%0h", mem_vis_status, IDLE); end
    checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL reset_instruction got=%h exp=%h", instruction, 32'h0); end
    checks++; if (mem_read_scalar_data !== 32'h0) begin failures++; $display("FAIL reset_scalar got=%h exp=0", mem_read_scalar_data); end
    checks++; if (mem_read_vector_data !== '0) begin failures++; $display("FAIL reset_vector got=%h exp=0", mem_read_vector_data); end
    do_req(OP_WR, DT_W, 17'h100, 4'd0, 32'h12345678, '0, n, fin, first, busy, post);
    checks++; if (fin !== DONE) begin failures++; $display("FAIL preload_status got=%0h exp=%0h", fin, DONE); end
    inst_fetch_enabled = 1'b1; mem_inst_addr = 17'h100;
    @(posedge clk); #1;
    inst_fetch_enabled = 1'b0; mem_inst_addr = 17'h104;
    checks++; if (instruction !== 32'h12345678) begin failures++; $display("FAIL fetch got=%h exp=%h", instruction, 32'h12345678); end
    @(posedge clk); #1;
    checks++; if (instruction !== 32'h12345678) begin failures++; $display("FAIL fetch_hold got=%h exp=%h", instruction, 32'h12345678); end
    // Illegal data_type and reserved op must both be ignored.
    mem_vis_enabled = 1'b1; memory_vis_signal = OP_RD; data_type = 3'b100;
    @(posedge clk); #1;
    checks++; if (mem_vis_status !== IDLE) begin failures++; $display("FAIL illegal_type got=%0h exp=%0h", mem_vis_status, IDLE); end
    memory_vis_signal = 2'b11; data_type = DT_W;
    @(posedge clk); #1;
    mem_vis_enabled = 1'b0; memory_vis_signal = 2'b00;
    checks++; if (mem_vis_status !== IDLE) begin failures++; $display("FAIL reserved_op got=%0h exp=%0h", mem_vis_status, IDLE); end
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_scalar();
    int n, busy; logic [1:0] fin, first, post;
    do_req(OP_WR, DT_W, 17'h200, 4'd0, 32'hDEADBEEF, '0, n, fin, first, busy, post);
    checks++; if (first !== BUSY) begin failures++; $display("FAIL wr_first_status got=%0h exp=%0h", first, BUSY); end
    checks++; if (busy !== 2) begin failures++; $display("FAIL wr_busy_cycles got=%0d exp=2", busy); end
    checks++; if (n !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", n); end
    checks++; if (fin !== DONE) begin failures++; $display("FAIL wr_done got=%0h exp=%0h", fin, DONE); end
    checks++; if (post !== IDLE) begin failures++; $display("FAIL wr_post_idle got=%0h exp=%0h", post, IDLE); end
    do_req(OP_RD, DT_B, 17'h201, 4'd0, '0, '0, n, fin, first, busy, post);
    checks++; if (mem_read_scalar_data !== 32'h000000BE) begin failures++; $display("FAIL byte_read got=%h exp=%h", mem_read_scalar_data, 32'hBE); end
    do_req(OP_RD, DT_H, 17'h202, 4'd0, '0, '0, n, fin, first, busy, post);
    checks++; if (mem_read_scalar_data !== 32'h0000DEAD) begin failures++; $display("FAIL half_read got=%h exp=%h", mem_read_scalar_data, 32'hDEAD); end
    checks++; if (n !== 3 || fin !== DONE) begin failures++; $display("FAIL half_latency got=%0d/%0h exp=3/%0h", n, fin, DONE); end
    do_req(OP_RD, DT_W, 17'h200, 4'd0, '0, '0, n, fin, first, busy, post);
    checks++; if (mem_read_scalar_data !== 32'hDEADBEEF) begin failures++; $display("FAIL word_read got=%h exp=%h", mem_read_scalar_data, 32'hDEADBEEF); end
    $display("test_scalar done checks=%0d", checks);
  endtask

  task automatic test_collision();
    // Fetch and data write hit 0x200 on the same edge; fetch must see the old word.
    mem_vis_enabled = 1'b1; memory_vis_signal = OP_WR; data_type = DT_W;
    mem_data_addr = 17'h200; mem_write_scalar_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_vis_enabled = 1'b0; memory_vis_signal = 2'b00;
    repeat (2) begin @(posedge clk); #1; end
    inst_fetch_enabled = 1'b1; mem_inst_addr = 17'h200;
    @(posedge clk); #1;
    inst_fetch_enabled = 1'b0;
    checks++; if (mem_vis_status !== DONE) begin failures++; $display("FAIL coll_status got=%0h exp=%0h", mem_vis_status, DONE); end
    checks++; if (instruction !== 32'hDEADBEEF) begin failures++; $display("FAIL coll_old_value got=%h exp=%h", instruction, 32'hDEADBEEF); end
    @(posedge clk); #1;
    inst_fetch_enabled = 1'b1;
    @(posedge clk); #1;
    inst_fetch_enabled = 1'b0;
    checks++; if (instruction !== 32'hCAFEF00D) begin failures++; $display("FAIL coll_new_value got=%h exp=%h", instruction, 32'hCAFEF00D); end
    $display("test_collision done checks=%0d", checks);
  endtask

  task automatic test_vector();
    int n, busy; logic [1:0] fin, first, post;
    logic [LEN*VS-1:0] wv, exp3, exp8;
    wv = '0; exp3 = '0;
    for (int i = 0; i < VS; i++) wv[LEN*i +: LEN] = 32'h11111111 * (i + 1);
    for (int i = 0; i < 3; i++) exp3[LEN*i +: LEN] = 32'h11111111 * (i + 1);
    exp8 = wv;
    do_req(OP_WR, DT_V, 17'h400, 4'd8, '0, wv, n, fin, first, busy, post);
    checks++; if (n !== 10 || fin !== DONE) begin failures++; $display("FAIL vwr8_latency got=%0d/%0h exp=10/%0h", n, fin, DONE); end
    do_req(OP_RD, DT_V, 17'h400, 4'd3, '0, '0, n, fin, first, busy, post);
    checks++; if (n !== 5 || fin !== DONE) begin failures++; $display("FAIL vrd3_latency got=%0d/%0h exp=5/%0h", n, fin, DONE); end
    checks++; if (mem_read_vector_data !== exp3) begin failures++; $display("FAIL vrd3_data got=%h exp=%h", mem_read_vector_data, exp3); end
    do_req(OP_RD, DT_V, 17'h400, 4'd15, '0, '0, n, fin, first, busy, post);
    checks++; if (n !== 10) begin failures++; $display("FAIL vrd15_clamp_latency got=%0d exp=10", n); end
    checks++; if (mem_read_vector_data !== exp8) begin failures++; $display("FAIL vrd15_data got=%h exp=%h", mem_read_vector_data, exp8); end
    $display("test_vector done checks=%0d", checks);
  endtask

  task automatic test_boundaries();
    int n, busy; logic [1:0] fin, first, post;
    logic [LEN*VS-1:0] exp8;
    for (int i = 0; i < VS; i++) exp8[LEN*i +: LEN] = 32'h11111111 * (i + 1);
    do_req(OP_WR, DT_V, 17'h400, 4'd0, '0, {VS{32'hFFFFFFFF}}, n, fin, first, busy, post);
    checks++; if (n !== 3 || fin !== DONE) begin failures++; $display("FAIL vwr0_latency got=%0d/%0h exp=3/%0h", n, fin, DONE); end
    do_req(OP_RD, DT_V, 17'h400, 4'd8, '0, '0, n, fin, first, busy, post);
    checks++; if (mem_read_vector_data !== exp8) begin failures++; $display("FAIL vwr0_no_change got=%h exp=%h", mem_read_vector_data, exp8); end
    do_req(OP_RD, DT_V, 17'h400, 4'd0, '0, '0, n, fin, first, busy, post);
    checks++; if (n !== 3 || mem_read_vector_data !== '0) begin failures++; $display("FAIL vrd0 got=%0d/%h exp=3/0", n, mem_read_vector_data); end
    do_req(OP_WR, DT_W, 17'h1FFFE, 4'd0, 32'hA1B2C3D4, '0, n, fin, first, busy, post);
`ifdef MEM_MISALIGN_CHECK_EN
    checks++; if (fin !== ERR) begin failures++; $display("FAIL wrap_err got=%0h exp=%0h", fin, ERR); end
`else
    checks++; if (fin !== DONE) begin failures++; $display("FAIL wrap_done got=%0h exp=%0h", fin, DONE); end
    do_req(OP_RD, DT_B, 17'h1FFFE, 4'd0, '0, '0, n, fin, first, busy, post);
    checks++; if (mem_read_scalar_data !== 32'hD4) begin failures++; $display("FAIL wrap_b0 got=%h exp=%h", mem_read_scalar_data, 32'hD4); end
    do_req(OP_RD, DT_B, 17'h1FFFF, 4'd0, '0, '0, n, fin, first, busy, post);
    checks++; if (mem_read_scalar_data !== 32'hC3) begin failures++; $display("FAIL wrap_b1 got=%h exp=%h", mem_read_scalar_data, 32'hC3); end
    do_req(OP_RD, DT_B, 17'h00000, 4'd0, '0, '0, n, fin, first, busy, post);
    checks++; if (mem_read_scalar_data !== 32'hB2) begin failures++; $display("FAIL wrap_b2 got=%h exp=%h", mem_read_scalar_data, 32'hB2); end
    do_req(OP_RD, DT_B, 17'h00001, 4'd0, '0, '0, n, fin, first, busy, post);
    checks++; if (mem_read_scalar_data !== 32'hA1) begin failures++; $display("FAIL wrap_b3 got=%h exp=%h", mem_read_scalar_data, 32'hA1); end
`endif
    $display("test_boundaries done checks=%0d", checks);
  endtask

  task automatic test_busy_request();
    int n, busy; logic [1:0] fin, first, post;
    do_req(OP_WR, DT_W, 17'h300, 4'd0, 32'h0BADF00D, '0, n, fin, first, busy, post);
    mem_vis_enabled = 1'b1; memory_vis_signal = OP_WR; data_type = DT_W;
    mem_data_addr = 17'h310; mem_write_scalar_data = 32'h5A5A5A5A;
    @(posedge clk); #1;
    // Competing request held through WAIT, ACCESS and the DONE edge.
    mem_data_addr = 17'h300; mem_write_scalar_data = 32'hFFFFFFFF;
    n = 0;
    while (n < 64 && mem_vis_status != DONE) begin
      @(posedge clk); #1; n++;
    end
    checks++; if (mem_vis_status !== DONE) begin failures++; $display("FAIL busy_req_done got=%0h exp=%0h", mem_vis_status, DONE); end
    @(posedge clk); #1;
    mem_vis_enabled = 1'b0; memory_vis_signal = 2'b00;
    checks++; if (mem_vis_status !== IDLE) begin failures++; $display("FAIL done_req_ignored got=%0h exp=%0h", mem_vis_status, IDLE); end
    @(posedge clk); #1;
    do_req(OP_RD, DT_W, 17'h310, 4'd0, '0, '0, n, fin, first, busy, post);
    checks++; if (mem_read_scalar_data !== 32'h5A5A5A5A) begin failures++; $display("FAIL busy_latched_ops got=%h exp=%h", mem_read_scalar_data, 32'h5A5A5A5A); end
    do_req(OP_RD, DT_W, 17'h300, 4'd0, '0, '0, n, fin, first, busy, post);
    checks++; if (mem_read_scalar_data !== 32'h0BADF00D) begin failures++; $display("FAIL busy_ignored_write got=%h exp=%h", mem_read_scalar_data, 32'h0BADF00D); end
    $display("test_busy_request done checks=%0d", checks);
  endtask

  task automatic test_reset_abort();
    int n, busy; logic [1:0] fin, first, post;
    logic [LEN*VS-1:0] wv, expv;
    do_req(OP_WR, DT_V, 17'h500, 4'd8, '0, '0, n, fin, first, busy, post);
    expv = '0;
    for (int i = 0; i < VS; i++) wv[LEN*i +: LEN] = 32'hA0000000 + i;
    for (int i = 0; i < 3; i++) expv[LEN*i +: LEN] = 32'hA0000000 + i;
    mem_vis_enabled = 1'b1; memory_vis_signal = OP_WR; data_type = DT_V;
    mem_data_addr = 17'h500; vector_length = 4'd8; mem_write_vector_data = wv;
    @(posedge clk); #1;
    mem_vis_enabled = 1'b0; memory_vis_signal = 2'b00;
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (mem_vis_status !== BUSY) begin failures++; $display("FAIL abort_pre_busy got=%0h exp=%0h", mem_vis_status, BUSY); end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++; if (mem_vis_status !== IDLE) begin failures++; $display("FAIL abort_idle got=%0h exp=%0h", mem_vis_status, IDLE); end
    do_req(OP_RD, DT_V, 17'h500, 4'd8, '0, '0, n, fin, first, busy, post);
    checks++; if (mem_read_vector_data !== expv) begin failures++; $display("FAIL abort_committed got=%h exp=%h", mem_read_vector_data, expv); end
    $display("test_reset_abort done checks=%0d", checks);
  endtask

  task automatic test_misalign();
    int n, busy; logic [1:0] fin, first, post;
    do_req(OP_WR, DT_W, 17'h600, 4'd0, 32'hDDCCBBAA, '0, n, fin, first, busy, post);
    do_req(OP_WR, DT_W, 17'h604, 4'd0, 32'h44332211, '0, n, fin, first, busy, post);
    do_req(OP_RD, DT_W, 17'h604, 4'd0, '0, '0, n, fin, first, busy, post);
    checks++; if (mem_read_scalar_data !== 32'h44332211) begin failures++; $display("FAIL mis_setup got=%h exp=%h", mem_read_scalar_data, 32'h44332211); end
    do_req(OP_RD, DT_W, 17'h603, 4'd0, '0, '0, n, fin, first, busy, post);
`ifdef MEM_MISALIGN_CHECK_EN
    checks++; if (fin !== ERR || n !== 3) begin failures++; $display("FAIL mis_error got=%0h/%0d exp=%0h/3", fin, n, ERR); end
    checks++; if (post !== IDLE) begin failures++; $display("FAIL mis_post_idle got=%0h exp=%0h", post, IDLE); end
    checks++; if (mem_read_scalar_data !== 32'h44332211) begin failures++; $display("FAIL mis_unchanged got=%h exp=%h", mem_read_scalar_data, 32'h44332211); end
`else
    checks++; if (fin !== DONE) begin failures++; $display("FAIL mis_done got=%0h exp=%0h", fin, DONE); end
    checks++; if (mem_read_scalar_data !== 32'h332211DD) begin failures++; $display("FAIL mis_word got=%h exp=%h", mem_read_scalar_data, 32'h332211DD); end
    do_req(OP_RD, DT_H, 17'h605, 4'd0, '0, '0, n, fin, first, busy, post);
    checks++; if (mem_read_scalar_data !== 32'h00003322) begin failures++; $display("FAIL mis_half got=%h exp=%h", mem_read_scalar_data, 32'h3322); end
`endif
    $display("test_misalign done checks=%0d", checks);
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_collision();
    test_vector();
    test_boundaries();
    test_busy_request();
    test_reset_abort();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
